// File: rtl/udma_hyperbus_pkg.sv
// -----------------------------------------------------------------------------
// udma_hyperbus_pkg
// Shared types and helpers for the HyperBus RX packer:
//   datasize_e  - uDMA beat size encoding (byte / halfword / word)
//   rxp_state_e - packer control states
//   RXP_BUF_BYTES - depth of the internal byte buffer
//   beat_bytes()  - datasize to beat width in bytes (1, 2 or 4)
//   byte_mask()   - 32-bit mask covering the lowest N bytes (N = 0..4)
// -----------------------------------------------------------------------------
package udma_hyperbus_pkg;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10
   } datasize_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } rxp_state_e;

   localparam int unsigned RXP_BUF_BYTES = 8;

   // Encoding 2'b11 is treated as a word, like 2'b10.
   function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
      unique case (ds)
         BYTE:    return 3'd1;
         HALF:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] byte_mask(input logic [2:0] cnt);
      unique case (cnt)
         3'd0:    return 32'h0000_0000;
         3'd1:    return 32'h0000_00FF;
         3'd2:    return 32'h0000_FFFF;
         3'd3:    return 32'h00FF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/udma_hyperbus_byte_buf.sv
// -----------------------------------------------------------------------------
// udma_hyperbus_byte_buf
// 8-byte little-endian shift buffer. Byte 0 (oldest) sits in bits [7:0].
// Each cycle it may pop 0..4 bytes from the bottom and append 0..4 bytes of a
// PHY word (after skipping its lowest push_skip_i bytes) on top of what is kept.
// Ports:
//   sys_clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i              synchronous flush
//   push_i             append push_cnt_i bytes of push_data_i >> (8*push_skip_i)
//   pop_cnt_i          bytes removed from the bottom this cycle (<= fcnt_o)
//   data_o             lowest four buffered bytes
//   fcnt_o             buffered byte count (0..8)
// -----------------------------------------------------------------------------
module udma_hyperbus_byte_buf
   import udma_hyperbus_pkg::*;
(
   input  logic        sys_clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        push_i,
   input  logic [31:0] push_data_i,
   input  logic [1:0]  push_skip_i,
   input  logic [2:0]  push_cnt_i,
   input  logic [2:0]  pop_cnt_i,
   output logic [31:0] data_o,
   output logic [3:0]  fcnt_o
);

   localparam int unsigned BUF_W = RXP_BUF_BYTES * 8;

   logic [BUF_W-1:0] buf_q, buf_d;
   logic [3:0]       fcnt_q, fcnt_d;
   logic [BUF_W-1:0] kept;
   logic [BUF_W-1:0] incoming;
   logic [3:0]       kept_cnt;
   logic [31:0]      aligned;

   // Bytes above fcnt are always zero, so new bytes can be OR-ed in place.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path
      // (here unconditionally, elsewhere as defaults first) so no latch is inferred.
      kept     = buf_q >> {pop_cnt_i, 3'b000};
      kept_cnt = fcnt_q - {1'b0, pop_cnt_i};
      aligned  = push_data_i >> {push_skip_i, 3'b000};
      incoming = '0;
      if (push_i) begin
         incoming = {32'd0, aligned & byte_mask(push_cnt_i)} << {kept_cnt, 3'b000};
      end
      buf_d  = kept | incoming;
      fcnt_d = kept_cnt + (push_i ? {1'b0, push_cnt_i} : 4'd0);
   end

   // NOTE: the buffer is a handful of flops, not a RAM, and is reset and flushed
   // to zero because the OR-insert above relies on unused bytes being zero.
   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst_ni) begin
         buf_q  <= '0;
         fcnt_q <= '0;
      end else if (clr_i) begin
         buf_q  <= '0;
         fcnt_q <= '0;
      end else begin
         buf_q  <= buf_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign data_o = buf_q[31:0];
   assign fcnt_o = fcnt_q;

endmodule

// File: rtl/udma_hyperbus_rx_packer.sv
// -----------------------------------------------------------------------------
// udma_hyperbus_rx_packer
// Repacks 32-bit little-endian HyperBus PHY read words into uDMA beats of the
// configured size, dropping the leading bytes of unaligned transfers and the
// trailing bytes beyond the transfer length; pulses eot_o when done.
// Ports:
//   sys_clk_i, rst_ni, clr_i       clock, async active-low reset, sync abort
//   cmd_valid_i/cmd_ready_o        descriptor handshake
//   cmd_size_i/offset_i/datasize_i length in bytes, start byte offset, beat size
//   phy_data_i/valid_i/ready_o     PHY word stream
//   rx_data_udma_o/valid_o/ready_i uDMA beat stream (zero-extended beats)
//   eot_o, busy_o                  end-of-transfer pulse, transfer in progress
// Optional: define UDMA_HYPER_RX_BYTESWAP_EN to add cfg_swap_i, which swaps the
// bytes inside each halfword of every PHY word of the command.
// -----------------------------------------------------------------------------
module udma_hyperbus_rx_packer
   import udma_hyperbus_pkg::*;
#(
   parameter int unsigned TRANS_SIZE = 16,
   parameter int unsigned BUF_BYTES  = RXP_BUF_BYTES
) (
   input  logic                  sys_clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [TRANS_SIZE-1:0] cmd_size_i,
   input  logic [1:0]            cmd_offset_i,
   input  logic [1:0]            cmd_datasize_i,
`ifdef UDMA_HYPER_RX_BYTESWAP_EN
   input  logic                  cfg_swap_i,
`endif
   input  logic [31:0]           phy_data_i,
   input  logic                  phy_valid_i,
   output logic                  phy_ready_o,
   output logic [31:0]           rx_data_udma_o,
   output logic                  rx_valid_udma_o,
   input  logic                  rx_ready_udma_i,
   output logic                  eot_o,
   output logic                  busy_o
);

   // A full PHY word fits only while at most BUF_BYTES-4 bytes are buffered.
   localparam logic [3:0]          PUSH_LIMIT = 4'(BUF_BYTES - 4);
   localparam logic [TRANS_SIZE:0] ONE_WORD   = (TRANS_SIZE+1)'(1);

   rxp_state_e              state_q, state_d;
   logic [TRANS_SIZE-1:0]   bytes_left_q, bytes_left_d;   // not yet handed to uDMA
   logic [TRANS_SIZE-1:0]   need_q, need_d;               // not yet pushed to buffer
   logic [TRANS_SIZE:0]     words_left_q, words_left_d;
   logic [1:0]              offset_q, offset_d;
   logic [2:0]              beat_q, beat_d;
   logic                    first_q, first_d;
   logic                    out_valid_q, out_valid_d;
   logic [31:0]             out_data_q, out_data_d;
   logic [2:0]              out_cnt_q, out_cnt_d;
   logic                    swap_q, swap_d;

   logic [31:0]             phy_word;
   logic [31:0]             buf_data;
   logic [3:0]              fcnt;
   logic                    push;
   logic [1:0]              skip;
   logic [2:0]              avail;
   logic [2:0]              push_cnt;
   logic [2:0]              pop_cnt;
   logic                    load_full, load_tail;
   logic                    phy_ready;
   logic [TRANS_SIZE:0]     span;
   logic [TRANS_SIZE-1:0]   bytes_after;

`ifdef UDMA_HYPER_RX_BYTESWAP_EN
   assign phy_word = swap_q ? {phy_data_i[23:16], phy_data_i[31:24],
                               phy_data_i[7:0],   phy_data_i[15:8]} : phy_data_i;
`else
   assign phy_word = phy_data_i;
`endif

   // Only the first word of a transfer carries leading bytes to drop; the last
   // word is truncated by limiting the push to the bytes still needed.
   assign skip     = first_q ? offset_q : 2'd0;
   assign avail    = 3'd4 - {1'b0, skip};
   assign push_cnt = (need_q < TRANS_SIZE'(avail)) ? need_q[2:0] : avail;

   // Load decisions use the pre-update count; bytes pushed this cycle are
   // visible to the output register from the next cycle on.
   assign load_full = (fcnt >= {1'b0, beat_q});
   assign load_tail = (words_left_q == '0) && (fcnt != '0) && (fcnt < {1'b0, beat_q});

   assign span = {1'b0, cmd_size_i} + (TRANS_SIZE+1)'(cmd_offset_i) + (TRANS_SIZE+1)'(3);

   always_comb begin
      state_d      = state_q;
      bytes_left_d = bytes_left_q;
      need_d       = need_q;
      words_left_d = words_left_q;
      offset_d     = offset_q;
      beat_d       = beat_q;
      first_d      = first_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_cnt_d    = out_cnt_q;
      swap_d       = swap_q;
      phy_ready    = 1'b0;
      push         = 1'b0;
      pop_cnt      = 3'd0;
      bytes_after  = bytes_left_q - TRANS_SIZE'(out_cnt_q);

      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               bytes_left_d = cmd_size_i;
               need_d       = cmd_size_i;
               words_left_d = span >> 2;
               offset_d     = cmd_offset_i;
               beat_d       = beat_bytes(cmd_datasize_i);
               first_d      = 1'b1;
`ifdef UDMA_HYPER_RX_BYTESWAP_EN
               swap_d       = cfg_swap_i;
`else
               swap_d       = 1'b0;
`endif
               state_d      = (cmd_size_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            phy_ready = (words_left_q != '0) && (fcnt <= PUSH_LIMIT);
            if (phy_ready && phy_valid_i) begin
               push         = 1'b1;
               need_d       = need_q - TRANS_SIZE'(push_cnt);
               words_left_d = words_left_q - ONE_WORD;
               first_d      = 1'b0;
            end
            if (out_valid_q && rx_ready_udma_i) begin
               out_valid_d  = 1'b0;
               bytes_left_d = bytes_after;
               if (bytes_after == '0) begin
                  state_d = DONE;
               end
            end
            if ((!out_valid_q || rx_ready_udma_i) && (load_full || load_tail)) begin
               pop_cnt     = load_full ? beat_q : fcnt[2:0];
               out_valid_d = 1'b1;
               out_data_d  = buf_data & byte_mask(pop_cnt);
               out_cnt_d   = pop_cnt;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over every other event in the same cycle.
      if (clr_i) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         push        = 1'b0;
         pop_cnt     = 3'd0;
      end
   end

   always_ff @(posedge sys_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         bytes_left_q <= '0;
         need_q       <= '0;
         words_left_q <= '0;
         offset_q     <= '0;
         beat_q       <= 3'd4;
         first_q      <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_cnt_q    <= '0;
         swap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bytes_left_q <= bytes_left_d;
         need_q       <= need_d;
         words_left_q <= words_left_d;
         offset_q     <= offset_d;
         beat_q       <= beat_d;
         first_q      <= first_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_cnt_q    <= out_cnt_d;
         swap_q       <= swap_d;
      end
   end

   udma_hyperbus_byte_buf i_byte_buf (
      .sys_clk_i   (sys_clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (clr_i),
      .push_i      (push),
      .push_data_i (phy_word),
      .push_skip_i (skip),
      .push_cnt_i  (push_cnt),
      .pop_cnt_i   (pop_cnt),
      .data_o      (buf_data),
      .fcnt_o      (fcnt)
   );

   assign cmd_ready_o     = (state_q == IDLE);
   assign phy_ready_o     = phy_ready;
   assign rx_data_udma_o  = out_data_q;
   assign rx_valid_udma_o = out_valid_q;
   assign eot_o           = (state_q == DONE);
   assign busy_o          = (state_q == RUN);

endmodule

// File: tb/tb_udma_hyperbus_rx_packer.sv
// -----------------------------------------------------------------------------
// tb_udma_hyperbus_rx_packer
// Directed bench for udma_hyperbus_rx_packer. Stimulus pushes expected beats
// into a scoreboard queue and PHY words into a driver queue; a monitor pops and
// compares every uDMA beat handshake. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_udma_hyperbus_rx_packer;

   logic        sys_clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        clr_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [15:0] cmd_size_i = '0;
   logic [1:0]  cmd_offset_i = '0;
   logic [1:0]  cmd_datasize_i = '0;
`ifdef UDMA_HYPER_RX_BYTESWAP_EN
   logic        cfg_swap_i = 1'b0;
`endif
   logic [31:0] phy_data_i;
   logic        phy_valid_i;
   logic        phy_ready_o;
   logic [31:0] rx_data_udma_o;
   logic        rx_valid_udma_o;
   logic        rx_ready_udma_i = 1'b1;
   logic        eot_o;
   logic        busy_o;

   udma_hyperbus_rx_packer #(.TRANS_SIZE(16)) dut (
      .sys_clk_i       (sys_clk_i),
      .rst_ni          (rst_ni),
      .clr_i           (clr_i),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_size_i      (cmd_size_i),
      .cmd_offset_i    (cmd_offset_i),
      .cmd_datasize_i  (cmd_datasize_i),
`ifdef UDMA_HYPER_RX_BYTESWAP_EN
      .cfg_swap_i      (cfg_swap_i),
`endif
      .phy_data_i      (phy_data_i),
      .phy_valid_i     (phy_valid_i),
      .phy_ready_o     (phy_ready_o),
      .rx_data_udma_o  (rx_data_udma_o),
      .rx_valid_udma_o (rx_valid_udma_o),
      .rx_ready_udma_i (rx_ready_udma_i),
      .eot_o           (eot_o),
      .busy_o          (busy_o)
   );

   always #5 sys_clk_i = ~sys_clk_i;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q[$];
   logic [31:0] phy_q[$];
   int cyc = 0;
   int beats_seen = 0;
   int eot_cnt = 0;
   int eot_cyc = -1;
   int last_hs_cyc = -1;
   int cmd_cnt = 0;
   int cmd_hs_cyc = -1;
   int words_taken = 0;

   always @(posedge sys_clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk_i);
         #1;
      end
   endtask

   // Monitor: beat scoreboard, hold-stability, eot and command bookkeeping.
   initial begin : monitor
      logic        pv, pr, pc;
      logic [31:0] pd;
      pv = 1'b0; pr = 1'b0; pc = 1'b0; pd = '0;
      forever begin
         @(negedge sys_clk_i);
         if (rst_ni) begin
            if (pv && !pr && !pc) begin
               check("hold_valid", {31'd0, rx_valid_udma_o}, 32'd1);
               check("hold_data", rx_data_udma_o, pd);
            end
            if (rx_valid_udma_o && rx_ready_udma_i) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got %h expected none", rx_data_udma_o);
               end else begin
                  check("beat", rx_data_udma_o, sb_q.pop_front());
               end
               beats_seen++;
               last_hs_cyc = cyc;
            end
            if (eot_o) begin
               eot_cnt++;
               eot_cyc = cyc;
            end
            if (cmd_valid_i && cmd_ready_o) begin
               cmd_cnt++;
               cmd_hs_cyc = cyc;
            end
         end
         pv = rx_valid_udma_o;
         pr = rx_ready_udma_i;
         pc = clr_i;
         pd = rx_data_udma_o;
      end
   end

   // PHY driver: presents the head of phy_q until it is accepted.
   initial begin : phy_drv
      logic hs;
      phy_valid_i = 1'b0;
      phy_data_i  = '0;
      forever begin
         @(negedge sys_clk_i);
         hs = phy_valid_i && phy_ready_o;
         @(posedge sys_clk_i);
         #1;
         if (hs && phy_q.size() > 0) begin
            void'(phy_q.pop_front());
            words_taken++;
         end
         if (phy_q.size() > 0) begin
            phy_valid_i = 1'b1;
            phy_data_i  = phy_q[0];
         end else begin
            phy_valid_i = 1'b0;
            phy_data_i  = '0;
         end
      end
   end

   task automatic send_cmd(input int size, input int off, input int ds);
      int c0;
      int guard;
      c0 = cmd_cnt;
      guard = 0;
      cmd_size_i     = 16'(size);
      cmd_offset_i   = 2'(off);
      cmd_datasize_i = 2'(ds);
      cmd_valid_i    = 1'b1;
      step();
      while (cmd_cnt == c0 && guard < 50) begin
         step();
         guard++;
      end
      cmd_valid_i = 1'b0;
      if (cmd_cnt == c0) fail_now("cmd_accept");
   endtask

   task automatic wait_eot(input string name, input bit after_cmd);
      int e0;
      int guard;
      e0 = eot_cnt;
      guard = 0;
      while (eot_cnt == e0 && guard < 500) begin
         step();
         guard++;
      end
      if (eot_cnt == e0) begin
         fail_now({name, "_eot"});
      end else begin
         check({name, "_eot_timing"}, eot_cyc, after_cmd ? cmd_hs_cyc + 1 : last_hs_cyc + 1);
         step(3);
         check({name, "_eot_single"}, eot_cnt, e0 + 1);
         check({name, "_busy_idle"}, {31'd0, busy_o}, 32'd0);
      end
   endtask

   task automatic end_xfer(input string name, input int w0, input int exp_words);
      check({name, "_words"}, words_taken - w0, exp_words);
      check({name, "_sb_empty"}, sb_q.size(), 0);
      phy_q.delete();
      step(2);
   endtask

   task automatic run_word_aligned(input string name);
      int w0;
      w0 = words_taken;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         b = 8'(4 * i);
         sb_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
         phy_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      send_cmd(16, 0, 2);
      wait_eot(name, 1'b0);
      end_xfer(name, w0, 4);
   endtask

   initial begin : stim
      int w0;
      int bs0;
      int guard;
      int e0;

      // Reset state.
      #12;
      check("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      check("rst_phy_ready", {31'd0, phy_ready_o}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid_udma_o}, 32'd0);
      check("rst_rx_data", rx_data_udma_o, 32'd0);
      check("rst_eot", {31'd0, eot_o}, 32'd0);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      step(2);
      rst_ni = 1'b1;
      step(2);

      // Word mode, aligned, four words.
      run_word_aligned("word");

      // Byte mode, offset 1, size 3; a trailing extra word must stay unread.
      w0 = words_taken;
      sb_q.push_back(32'h0000_00BB);
      sb_q.push_back(32'h0000_00CC);
      sb_q.push_back(32'h0000_00DD);
      phy_q.push_back(32'hDDCC_BBAA);
      phy_q.push_back(32'h1234_5678);
      send_cmd(3, 1, 0);
      wait_eot("byte", 1'b0);
      end_xfer("byte", w0, 1);

      // Halfword mode, offset 2, size 5 with odd tail.
      w0 = words_taken;
      sb_q.push_back(32'h0000_4433);
      sb_q.push_back(32'h0000_6655);
      sb_q.push_back(32'h0000_0077);
      phy_q.push_back(32'h4433_2211);
      phy_q.push_back(32'h8877_6655);
      send_cmd(5, 2, 1);
      wait_eot("half", 1'b0);
      end_xfer("half", w0, 2);

      // Backpressure: word mode, 32 bytes, uDMA stalls for 10 cycles.
      w0 = words_taken;
      bs0 = beats_seen;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'(4 * i);
         sb_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
         phy_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      send_cmd(32, 0, 2);
      guard = 0;
      while (beats_seen < bs0 + 2 && guard < 100) begin
         step();
         guard++;
      end
      if (beats_seen < bs0 + 2) fail_now("bp_first_beats");
      rx_ready_udma_i = 1'b0;
      step(10);
      check("bp_phy_ready_low", {31'd0, phy_ready_o}, 32'd0);
      check("bp_rx_valid_held", {31'd0, rx_valid_udma_o}, 32'd1);
      rx_ready_udma_i = 1'b1;
      wait_eot("bp", 1'b0);
      end_xfer("bp", w0, 8);

      // Zero-length command: eot next cycle, no PHY reads.
      w0 = words_taken;
      phy_q.push_back(32'hCAFE_F00D);
      send_cmd(0, 0, 2);
      wait_eot("size0", 1'b1);
      end_xfer("size0", w0, 0);

      // Abort after two of eight beats.
      bs0 = beats_seen;
      e0 = eot_cnt;
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'(4 * i + 64);
         sb_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
         phy_q.push_back({b + 8'd3, b + 8'd2, b + 8'd1, b});
      end
      send_cmd(32, 0, 2);
      guard = 0;
      while (beats_seen < bs0 + 2 && guard < 100) begin
         step();
         guard++;
      end
      if (beats_seen < bs0 + 2) fail_now("clr_first_beats");
      clr_i = 1'b1;
      rx_ready_udma_i = 1'b0;
      phy_q.delete();
      sb_q.delete();
      step();
      clr_i = 1'b0;
      check("clr_busy", {31'd0, busy_o}, 32'd0);
      check("clr_rx_valid", {31'd0, rx_valid_udma_o}, 32'd0);
      check("clr_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
      rx_ready_udma_i = 1'b1;
      step(5);
      check("clr_no_eot", eot_cnt, e0);
      check("clr_no_beats", beats_seen - bs0, 2);
      run_word_aligned("post_clr");

`ifdef UDMA_HYPER_RX_BYTESWAP_EN
      // Halfword byte swap.
      w0 = words_taken;
      cfg_swap_i = 1'b1;
      sb_q.push_back(32'h3344_1122);
      phy_q.push_back(32'h4433_2211);
      send_cmd(4, 0, 2);
      cfg_swap_i = 1'b0;
      wait_eot("swap", 1'b0);
      end_xfer("swap", w0, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
